// File: rtl/bytecode_fetcher_if.sv
// Fetcher-side bus bundle: memory address/data, decoder handshake and redirect.
// Modport master belongs to the fetcher, slave to the memory/decoder environment.
interface bytecode_fetcher_if #(
   parameter int BYTE         = 8,
   parameter int MAX_OPERANDS = 2,
   parameter int ADDR_W       = 9
) ();
   logic [ADDR_W-1:0]                 memory_pointer;
   logic [BYTE-1:0]                   data_from_memory;
   logic [BYTE*(MAX_OPERANDS+1)-1:0]  data_for_decoder;
   logic [1:0]                        operand_count;
   logic                              start_for_decoder;
   logic                              ready_from_decoder;
   logic                              pc_load;
   logic [ADDR_W-1:0]                 pc_load_addr;

   modport master (
      output memory_pointer, data_for_decoder, operand_count, start_for_decoder,
      input  data_from_memory, ready_from_decoder, pc_load, pc_load_addr
   );

   modport slave (
      input  memory_pointer, data_for_decoder, operand_count, start_for_decoder,
      output data_from_memory, ready_from_decoder, pc_load, pc_load_addr
   );
endinterface

// File: rtl/bytecode_fetcher.sv
// Bytecode fetcher: assembles opcode plus operand bytes and hands them to the decoder.
// Optional macro FETCH_DEBUG_EN adds state and instr_count observation outputs.
module bytecode_fetcher #(
   parameter int               BYTE         = 8,
   parameter int               MAX_OPERANDS = 2,
   parameter int               ADDR_W       = 9,
   parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
   input  logic                 clk,
   input  logic                 reset,
   bytecode_fetcher_if.master   bus
`ifdef FETCH_DEBUG_EN
   ,
   output logic [1:0]           state,
   output logic [15:0]          instr_count
`endif
);
   localparam int DW = BYTE * (MAX_OPERANDS + 1);

   typedef enum logic [1:0] {
      FETCH_OP   = 2'd0,
      FETCH_OPND = 2'd1,
      SEND       = 2'd2
   } state_e;

   state_e            state_q;
   logic [ADDR_W-1:0] ptr_q;
   logic [DW-1:0]     data_q;
   logic [1:0]        opcnt_q;
   logic [1:0]        idx_q;
   logic              start_q;
   logic [1:0]        opcnt_d;
   logic              xfer_s;

   // Operand-byte count per opcode, clamped to what the output word can hold.
   function automatic logic [1:0] lookup_operands(input logic [BYTE-1:0] op);
      logic [1:0] raw;
      logic [1:0] res;
      raw = 2'd0;
      if ((op == BYTE'(8'h10)) || (op == BYTE'(8'h12)) || (op == BYTE'(8'hA9)) ||
          ((op >= BYTE'(8'h15)) && (op <= BYTE'(8'h19))) ||
          ((op >= BYTE'(8'h36)) && (op <= BYTE'(8'h3A)))) begin
         raw = 2'd1;
      end else if ((op == BYTE'(8'h11)) || (op == BYTE'(8'h13)) || (op == BYTE'(8'h14)) ||
                   (op == BYTE'(8'h84)) ||
                   ((op >= BYTE'(8'h99)) && (op <= BYTE'(8'hA8)))) begin
         raw = 2'd2;
      end else begin
         raw = 2'd0;
      end
      if (int'(raw) > MAX_OPERANDS) begin
         res = 2'(MAX_OPERANDS);
      end else begin
         res = raw;
      end
      return res;
   endfunction

   // Opcode decode and decoder handshake qualification.
   always_comb begin
      opcnt_d = lookup_operands(bus.data_from_memory);
      xfer_s  = start_q & bus.ready_from_decoder;
   end

   // Fetch FSM; reset dominates redirect, redirect dominates normal sequencing.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FETCH_OP;
         ptr_q   <= RESET_ADDR;
         data_q  <= '0;
         opcnt_q <= 2'd0;
         idx_q   <= 2'd0;
         start_q <= 1'b0;
      end else if (bus.pc_load) begin
         state_q <= FETCH_OP;
         ptr_q   <= bus.pc_load_addr;
         idx_q   <= 2'd0;
         start_q <= 1'b0;
      end else begin
         case (state_q)
            FETCH_OP: begin
               data_q  <= {bus.data_from_memory, {(DW-BYTE){1'b0}}};
               opcnt_q <= opcnt_d;
               idx_q   <= 2'd0;
               ptr_q   <= ptr_q + ADDR_W'(1);
               if (opcnt_d == 2'd0) begin
                  state_q <= SEND;
                  start_q <= 1'b1;
               end else begin
                  state_q <= FETCH_OPND;
                  start_q <= 1'b0;
               end
            end
            FETCH_OPND: begin
               // Operand k lands directly below the opcode, k-th byte from the top.
               data_q[BYTE*(MAX_OPERANDS-1-int'(idx_q)) +: BYTE] <= bus.data_from_memory;
               idx_q <= idx_q + 2'd1;
               ptr_q <= ptr_q + ADDR_W'(1);
               if (idx_q == (opcnt_q - 2'd1)) begin
                  state_q <= SEND;
                  start_q <= 1'b1;
               end else begin
                  state_q <= FETCH_OPND;
                  start_q <= 1'b0;
               end
            end
            SEND: begin
               if (xfer_s) begin
                  state_q <= FETCH_OP;
                  start_q <= 1'b0;
               end else begin
                  state_q <= SEND;
                  start_q <= 1'b1;
               end
            end
            default: begin
               state_q <= FETCH_OP;
               start_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.memory_pointer    = ptr_q;
   assign bus.data_for_decoder  = data_q;
   assign bus.operand_count     = opcnt_q;
   assign bus.start_for_decoder = start_q;

`ifdef FETCH_DEBUG_EN
   logic [15:0] instr_count_q;

   // Completed-transfer counter; a transfer coinciding with a redirect still counts.
   always_ff @(posedge clk) begin
      if (reset) begin
         instr_count_q <= 16'd0;
      end else if (xfer_s) begin
         instr_count_q <= instr_count_q + 16'd1;
      end else begin
         instr_count_q <= instr_count_q;
      end
   end

   assign state       = state_q;
   assign instr_count = instr_count_q;
`endif
endmodule

// File: tb/tb_bytecode_fetcher.sv
// Directed testbench for bytecode_fetcher: one task per scenario, inline checks.
// Second instance uses RESET_ADDR 0x1FF to exercise pointer wrap.
module tb_bytecode_fetcher;
   logic clk;
   logic reset;
   logic [7:0] mem [0:511];
   int tests;
   int failed;

   bytecode_fetcher_if #(.BYTE(8), .MAX_OPERANDS(2), .ADDR_W(9)) if0 ();
   bytecode_fetcher_if #(.BYTE(8), .MAX_OPERANDS(2), .ADDR_W(9)) if1 ();

`ifdef FETCH_DEBUG_EN
   logic [1:0]  st0, st1;
   logic [15:0] ic0, ic1;
`endif

   bytecode_fetcher #(.BYTE(8), .MAX_OPERANDS(2), .ADDR_W(9), .RESET_ADDR(9'h000)) dut0 (
      .clk(clk), .reset(reset), .bus(if0)
`ifdef FETCH_DEBUG_EN
      , .state(st0), .instr_count(ic0)
`endif
   );

   bytecode_fetcher #(.BYTE(8), .MAX_OPERANDS(2), .ADDR_W(9), .RESET_ADDR(9'h1FF)) dut1 (
      .clk(clk), .reset(reset), .bus(if1)
`ifdef FETCH_DEBUG_EN
      , .state(st1), .instr_count(ic1)
`endif
   );

   assign if0.data_from_memory   = mem[if0.memory_pointer];
   assign if1.data_from_memory   = mem[if1.memory_pointer];
   assign if1.ready_from_decoder = if0.ready_from_decoder;
   assign if1.pc_load            = if0.pc_load;
   assign if1.pc_load_addr       = if0.pc_load_addr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      if0.ready_from_decoder = 1'b0;
      if0.pc_load = 1'b0;
      if0.pc_load_addr = 9'h000;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      if0.ready_from_decoder = 1'b0;
      if0.pc_load = 1'b0;
      if0.pc_load_addr = 9'h000;
      tick();
      tick();
      tests++; if (if0.memory_pointer !== 9'h000) begin failed++; $display("FAIL reset_ptr: got %h expected 000", if0.memory_pointer); end
      tests++; if (if0.start_for_decoder !== 1'b0) begin failed++; $display("FAIL reset_start: got %b expected 0", if0.start_for_decoder); end
      tests++; if (if0.data_for_decoder !== 24'h000000) begin failed++; $display("FAIL reset_data: got %h expected 000000", if0.data_for_decoder); end
      tests++; if (if0.operand_count !== 2'd0) begin failed++; $display("FAIL reset_cnt: got %0d expected 0", if0.operand_count); end
`ifdef FETCH_DEBUG_EN
      tests++; if (st0 !== 2'd0) begin failed++; $display("FAIL reset_state: got %0d expected 0", st0); end
`endif
   endtask

   task automatic test_no_operand();
      mem[0] = 8'h03; mem[1] = 8'h04;
      do_reset();
      if0.ready_from_decoder = 1'b1;
      tests++; if (if0.memory_pointer !== 9'h000) begin failed++; $display("FAIL noop_ptr0: got %h expected 000", if0.memory_pointer); end
      tick();
      tests++; if (if0.start_for_decoder !== 1'b1) begin failed++; $display("FAIL noop_start1: got %b expected 1", if0.start_for_decoder); end
      tests++; if (if0.data_for_decoder !== 24'h030000) begin failed++; $display("FAIL noop_data1: got %h expected 030000", if0.data_for_decoder); end
      tests++; if (if0.operand_count !== 2'd0) begin failed++; $display("FAIL noop_cnt1: got %0d expected 0", if0.operand_count); end
      tests++; if (if0.memory_pointer !== 9'h001) begin failed++; $display("FAIL noop_ptr1: got %h expected 001", if0.memory_pointer); end
      tick();
      tests++; if (if0.start_for_decoder !== 1'b0) begin failed++; $display("FAIL noop_pulse: got %b expected 0", if0.start_for_decoder); end
      tick();
      tests++; if (if0.data_for_decoder !== 24'h040000) begin failed++; $display("FAIL noop_data2: got %h expected 040000", if0.data_for_decoder); end
      tests++; if (if0.memory_pointer !== 9'h002) begin failed++; $display("FAIL noop_ptr2: got %h expected 002", if0.memory_pointer); end
      tick();
      tests++; if (if0.start_for_decoder !== 1'b0) begin failed++; $display("FAIL noop_pulse2: got %b expected 0", if0.start_for_decoder); end
`ifdef FETCH_DEBUG_EN
      tests++; if (ic0 !== 16'd2) begin failed++; $display("FAIL noop_icount: got %0d expected 2", ic0); end
`endif
   endtask

   task automatic test_sipush();
      mem[0] = 8'h11; mem[1] = 8'h12; mem[2] = 8'h34;
      do_reset();
      tick();
      tests++; if (if0.start_for_decoder !== 1'b0) begin failed++; $display("FAIL sipush_start_c1: got %b expected 0", if0.start_for_decoder); end
      tick();
      tests++; if (if0.start_for_decoder !== 1'b0) begin failed++; $display("FAIL sipush_start_c2: got %b expected 0", if0.start_for_decoder); end
      tick();
      tests++; if (if0.start_for_decoder !== 1'b1) begin failed++; $display("FAIL sipush_start_c3: got %b expected 1", if0.start_for_decoder); end
      tests++; if (if0.data_for_decoder !== 24'h111234) begin failed++; $display("FAIL sipush_data: got %h expected 111234", if0.data_for_decoder); end
      tests++; if (if0.operand_count !== 2'd2) begin failed++; $display("FAIL sipush_cnt: got %0d expected 2", if0.operand_count); end
      tests++; if (if0.memory_pointer !== 9'h003) begin failed++; $display("FAIL sipush_ptr: got %h expected 003", if0.memory_pointer); end
      if0.ready_from_decoder = 1'b1;
      tick();
      tests++; if (if0.start_for_decoder !== 1'b0) begin failed++; $display("FAIL sipush_xfer: got %b expected 0", if0.start_for_decoder); end
   endtask

   task automatic test_one_operand();
      mem[0] = 8'hA9; mem[1] = 8'h77; mem[2] = 8'h99; mem[3] = 8'h01; mem[4] = 8'h02;
      do_reset();
      if0.ready_from_decoder = 1'b1;
      tick();
      tick();
      tests++; if (if0.data_for_decoder !== 24'hA97700) begin failed++; $display("FAIL one_data: got %h expected A97700", if0.data_for_decoder); end
      tests++; if (if0.operand_count !== 2'd1) begin failed++; $display("FAIL one_cnt: got %0d expected 1", if0.operand_count); end
      tests++; if (if0.start_for_decoder !== 1'b1) begin failed++; $display("FAIL one_start: got %b expected 1", if0.start_for_decoder); end
      tick();
      tick();
      tick();
      tick();
      tests++; if (if0.data_for_decoder !== 24'h990102) begin failed++; $display("FAIL two_data: got %h expected 990102", if0.data_for_decoder); end
      tests++; if (if0.operand_count !== 2'd2) begin failed++; $display("FAIL two_cnt: got %0d expected 2", if0.operand_count); end
      tests++; if (if0.memory_pointer !== 9'h005) begin failed++; $display("FAIL two_ptr: got %h expected 005", if0.memory_pointer); end
   endtask

   task automatic test_stall();
      mem[0] = 8'h6F;
      do_reset();
      tick();
      tests++; if (if0.start_for_decoder !== 1'b1) begin failed++; $display("FAIL stall_start0: got %b expected 1", if0.start_for_decoder); end
      for (int i = 0; i < 3; i++) begin
         tick();
         tests++; if ({if0.start_for_decoder, if0.data_for_decoder, if0.memory_pointer} !== {1'b1, 24'h6F0000, 9'h001}) begin failed++; $display("FAIL stall_hold%0d: got %b/%h/%h expected 1/6F0000/001", i, if0.start_for_decoder, if0.data_for_decoder, if0.memory_pointer); end
      end
      if0.ready_from_decoder = 1'b1;
      tick();
      tests++; if (if0.start_for_decoder !== 1'b0) begin failed++; $display("FAIL stall_xfer: got %b expected 0", if0.start_for_decoder); end
   endtask

   task automatic test_pc_load();
      mem[0] = 8'h10; mem[1] = 8'hAA; mem[9'h080] = 8'h05;
      do_reset();
      if0.ready_from_decoder = 1'b1;
      tick();
      if0.pc_load = 1'b1;
      if0.pc_load_addr = 9'h080;
      tick();
      if0.pc_load = 1'b0;
      tests++; if (if0.memory_pointer !== 9'h080) begin failed++; $display("FAIL redir_ptr: got %h expected 080", if0.memory_pointer); end
      tests++; if (if0.start_for_decoder !== 1'b0) begin failed++; $display("FAIL redir_start: got %b expected 0", if0.start_for_decoder); end
      tick();
      tests++; if (if0.data_for_decoder !== 24'h050000) begin failed++; $display("FAIL redir_data: got %h expected 050000", if0.data_for_decoder); end
      tests++; if (if0.memory_pointer !== 9'h081) begin failed++; $display("FAIL redir_ptr2: got %h expected 081", if0.memory_pointer); end
   endtask

   task automatic test_pc_load_xfer();
      mem[0] = 8'h6F; mem[9'h100] = 8'h07;
      do_reset();
      tick();
      if0.ready_from_decoder = 1'b1;
      if0.pc_load = 1'b1;
      if0.pc_load_addr = 9'h100;
      tick();
      if0.pc_load = 1'b0;
      if0.ready_from_decoder = 1'b0;
      tests++; if (if0.memory_pointer !== 9'h100) begin failed++; $display("FAIL redirx_ptr: got %h expected 100", if0.memory_pointer); end
      tests++; if (if0.start_for_decoder !== 1'b0) begin failed++; $display("FAIL redirx_start: got %b expected 0", if0.start_for_decoder); end
      tick();
      tests++; if (if0.data_for_decoder !== 24'h070000) begin failed++; $display("FAIL redirx_data: got %h expected 070000", if0.data_for_decoder); end
`ifdef FETCH_DEBUG_EN
      tests++; if (ic0 !== 16'd1) begin failed++; $display("FAIL redirx_icount: got %0d expected 1", ic0); end
`endif
   endtask

   task automatic test_wrap();
      mem[9'h1FF] = 8'h91;
      do_reset();
      tests++; if (if1.memory_pointer !== 9'h1FF) begin failed++; $display("FAIL wrap_ptr0: got %h expected 1FF", if1.memory_pointer); end
      tick();
      tests++; if (if1.memory_pointer !== 9'h000) begin failed++; $display("FAIL wrap_ptr1: got %h expected 000", if1.memory_pointer); end
      tests++; if (if1.data_for_decoder !== 24'h910000) begin failed++; $display("FAIL wrap_data: got %h expected 910000", if1.data_for_decoder); end
      tests++; if (if1.start_for_decoder !== 1'b1) begin failed++; $display("FAIL wrap_start: got %b expected 1", if1.start_for_decoder); end
   endtask

   task automatic test_reset_in_send();
      mem[0] = 8'h50;
      do_reset();
      tick();
      tests++; if (if0.start_for_decoder !== 1'b1) begin failed++; $display("FAIL rsend_start0: got %b expected 1", if0.start_for_decoder); end
      reset = 1'b1;
      if0.pc_load = 1'b1;
      if0.pc_load_addr = 9'h055;
      tick();
      reset = 1'b0;
      if0.pc_load = 1'b0;
      tests++; if (if0.start_for_decoder !== 1'b0) begin failed++; $display("FAIL rsend_start: got %b expected 0", if0.start_for_decoder); end
      tests++; if (if0.memory_pointer !== 9'h000) begin failed++; $display("FAIL rsend_ptr: got %h expected 000", if0.memory_pointer); end
      tests++; if (if0.data_for_decoder !== 24'h000000) begin failed++; $display("FAIL rsend_data: got %h expected 000000", if0.data_for_decoder); end
`ifdef FETCH_DEBUG_EN
      tests++; if (ic0 !== 16'd0) begin failed++; $display("FAIL rsend_icount: got %0d expected 0", ic0); end
`endif
      tick();
      tests++; if (if0.data_for_decoder !== 24'h500000) begin failed++; $display("FAIL rsend_refetch: got %h expected 500000", if0.data_for_decoder); end
      tests++; if (if0.memory_pointer !== 9'h001) begin failed++; $display("FAIL rsend_ptr1: got %h expected 001", if0.memory_pointer); end
   endtask

   initial begin
      tests = 0;
      failed = 0;
      for (int i = 0; i < 512; i++) mem[i] = 8'h00;
      test_reset();
      test_no_operand();
      test_sipush();
      test_one_operand();
      test_stall();
      test_pc_load();
      test_pc_load_xfer();
      test_wrap();
      test_reset_in_send();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
